dmem_bus_bridge: RTL and testbench

Multi-cycle load/store bridge between the core datapath and an external data-memory bus with a req/ack handshake. It replaces direct use of the internal single-cycle data memory: it consumes the ALU result (effective address), rs2 (store data) and the cu's mem_read/mem_write codes, and produces load-aligned write-back data. It stalls the core while a bus transaction is outstanding. It handles byte-lane steering, sign/zero extension, misalignment detection and a bus timeout.

---
 rtl/dmem_bus_bridge.sv | 173 +++++++++++++++++
 tb/tb_dmem_bus_bridge.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// Multi-cycle load/store bridge from the core datapath to a req/ack data-memory bus.
// Handles lane steering, load extension, misalignment rejection and bus timeout.
module dmem_bus_bridge #(
  parameter int unsigned N        = 32,
  parameter int unsigned MEM_ADDR = 8,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          mem_read,
  input  logic [1:0]          mem_write,
  input  logic [N-1:0]        r,
  input  logic [N-1:0]        rs2,
  output logic [N-1:0]        read_data_out,
  output logic                stall,
  output logic                misalign,
  output logic                bus_err,
  output logic                bus_req,
  output logic                bus_we,
  output logic [MEM_ADDR-1:0] bus_addr,
  output logic [3:0]          bus_be,
  output logic [N-1:0]        bus_wdata,
  input  logic                bus_ack,
  input  logic [N-1:0]        bus_rdata
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          ld_q, ld_d;
  logic [1:0]          off_q, off_d;
  logic [N-1:0]        rdata_d;
  logic                err_d;
  logic                we_d;
  logic [MEM_ADDR-1:0] addr_d;
  logic [3:0]          be_d;
  logic [N-1:0]        wdata_d;

  logic                is_write, is_read, access, misaligned;
  logic [1:0]          size;
  logic [N-1:0]        shifted, load_val;

  // Upper address bits are outside the bus window.
  logic unused_r;
  assign unused_r = ^r[N-1:MEM_ADDR];

  // Access decode; a write wins over a simultaneous read code.
  always_comb begin
    is_write = (mem_write != 2'b00);
    is_read  = (mem_read >= 3'd1) && (mem_read <= 3'd5);
    access   = is_write || is_read;
    size     = 2'd0;
    if (is_write) begin
      size = mem_write - 2'd1;
    end else begin
      case (mem_read)
        3'd2, 3'd5: size = 2'd1;
        3'd3:       size = 2'd2;
        default:    size = 2'd0;
      endcase
    end
    misaligned = ((size == 2'd1) && r[0]) || ((size == 2'd2) && (r[1:0] != 2'b00));
  end

  // Load extraction from the captured byte offset and load type.
  always_comb begin
    shifted  = bus_rdata >> {off_q, 3'b000};
    load_val = '0;
    case (ld_q)
      3'd1:    load_val = {{(N-8){shifted[7]}}, shifted[7:0]};
      3'd2:    load_val = {{(N-16){shifted[15]}}, shifted[15:0]};
      3'd3:    load_val = bus_rdata;
      3'd4:    load_val = {{(N-8){1'b0}}, shifted[7:0]};
      3'd5:    load_val = {{(N-16){1'b0}}, shifted[15:0]};
      default: load_val = '0;
    endcase
  end

  // Next-state and next-register values; stall/misalign are combinational by design.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_d     = ld_q;
    off_d    = off_q;
    rdata_d  = read_data_out;
    err_d    = 1'b0;
    we_d     = bus_we;
    addr_d   = bus_addr;
    be_d     = bus_be;
    wdata_d  = bus_wdata;
    stall    = 1'b0;
    misalign = 1'b0;

    case (state_q)
      IDLE: begin
        if (access && misaligned) begin
          misalign = !rst;
          rdata_d  = '0;
        end else if (access) begin
          stall   = !rst;
          state_d = BUS;
          cnt_d   = '0;
          off_d   = r[1:0];
          addr_d  = {r[MEM_ADDR-1:2], 2'b00};
          we_d    = is_write;
          ld_d    = is_write ? 3'd0 : mem_read;
          be_d    = 4'hF;
          wdata_d = '0;
          if (is_write) begin
            case (mem_write)
              2'b01: begin
                wdata_d = {4{rs2[7:0]}};
                be_d    = 4'b0001 << r[1:0];
              end
              2'b10: begin
                wdata_d = {2{rs2[15:0]}};
                be_d    = r[1] ? 4'b1100 : 4'b0011;
              end
              default: wdata_d = rs2;
            endcase
          end
        end
      end
      BUS: begin
        stall = !rst;
        if (bus_ack) begin
          state_d = DONE;
          rdata_d = bus_we ? '0 : load_val;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus_req = (state_q == BUS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ld_q          <= '0;
      off_q         <= '0;
      read_data_out <= '0;
      bus_err       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_be        <= '0;
      bus_wdata     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ld_q          <= ld_d;
      off_q         <= off_d;
      read_data_out <= rdata_d;
      bus_err       <= err_d;
      bus_we        <= we_d;
      bus_addr      <= addr_d;
      bus_be        <= be_d;
      bus_wdata     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: expectations queued at issue, compared at DONE.
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] r, rs2;
  logic [31:0] read_data_out;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [7:0]  bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        err;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t sb[$];

  dmem_bus_bridge #(.N(32), .MEM_ADDR(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .r(r), .rs2(rs2), .read_data_out(read_data_out), .stall(stall),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read  = 3'd0;
    mem_write = 2'd0;
    r         = '0;
    rs2       = '0;
    bus_ack   = 1'b0;
  endtask

  // Issue one access; ack_at = BUS cycle (1-based) to ack in, 0 = never ack.
  task automatic run_access(input string tag, input logic [2:0] mr, input logic [1:0] mw,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rdat, input int ack_at, input exp_t e);
    int   stalls = 0;
    int   reqs   = 0;
    bit   done   = 0;
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    mem_read  = mr;
    mem_write = mw;
    r         = addr;
    rs2       = data;
    bus_rdata = rdat;
    bus_ack   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (stall) begin
        stalls++;
        if (bus_req) reqs++;
        bus_ack = bus_req && (reqs == ack_at);
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    check({tag, " done"}, 32'(done), 32'd1);
    x = sb.pop_front();
    check({x.tag, " rdata"}, read_data_out, x.rd);
    check({x.tag, " err"}, 32'(bus_err), 32'(x.err));
    check({x.tag, " addr"}, 32'(bus_addr), 32'(x.addr));
    check({x.tag, " be"}, 32'(bus_be), 32'(x.be));
    check({x.tag, " we"}, 32'(bus_we), 32'(x.we));
    check({x.tag, " wdata"}, bus_wdata, x.wdata);
    check({x.tag, " stalls"}, 32'(stalls), 32'(x.stalls));
    check({x.tag, " reqs"}, 32'(reqs), 32'(x.reqs));
    check({x.tag, " req_done"}, 32'(bus_req), 32'd0);
    clear_inputs();
  endtask

  task automatic run_misalign(input string tag, input logic [2:0] mr, input logic [1:0] mw,
                              input logic [31:0] addr);
    @(negedge clk);
    mem_read  = mr;
    mem_write = mw;
    r         = addr;
    rs2       = 32'h5555_5555;
    #1;
    check({tag, " pulse"}, 32'(misalign), 32'd1);
    check({tag, " stall"}, 32'(stall), 32'd0);
    check({tag, " req"}, 32'(bus_req), 32'd0);
    @(negedge clk);
    clear_inputs();
    #1;
    check({tag, " pulse_end"}, 32'(misalign), 32'd0);
    check({tag, " req_after"}, 32'(bus_req), 32'd0);
    check({tag, " rdata"}, read_data_out, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " req"}, 32'(bus_req), 32'd0);
    check({tag, " stall"}, 32'(stall), 32'd0);
    check({tag, " we"}, 32'(bus_we), 32'd0);
    check({tag, " addr"}, 32'(bus_addr), 32'd0);
    check({tag, " be"}, 32'(bus_be), 32'd0);
    check({tag, " wdata"}, bus_wdata, 32'd0);
    check({tag, " rdata"}, read_data_out, 32'd0);
    check({tag, " misalign"}, 32'(misalign), 32'd0);
    check({tag, " err"}, 32'(bus_err), 32'd0);
  endtask

  initial begin
    exp_t e;
    clear_inputs();
    bus_rdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Ack outside BUS must not start anything.
    bus_ack = 1'b1;
    @(negedge clk);
    #1;
    check("stray_ack req", 32'(bus_req), 32'd0);
    check("stray_ack stall", 32'(stall), 32'd0);
    bus_ack = 1'b0;

    e = '{"LW", 32'hDEADBEEF, 1'b0, 8'h10, 4'hF, 1'b0, 32'h0, 2, 1};
    run_access("LW", 3'd3, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1, e);

    run_misalign("LW_mis", 3'd3, 2'd0, 32'h02);

    e = '{"LB", 32'hFFFFFF80, 1'b0, 8'h10, 4'hF, 1'b0, 32'h0, 2, 1};
    run_access("LB", 3'd1, 2'd0, 32'h13, 32'h0, 32'h80112233, 1, e);
    e = '{"LBU", 32'h00000080, 1'b0, 8'h10, 4'hF, 1'b0, 32'h0, 2, 1};
    run_access("LBU", 3'd4, 2'd0, 32'h13, 32'h0, 32'h80112233, 1, e);
    e = '{"LHU", 32'h00008011, 1'b0, 8'h10, 4'hF, 1'b0, 32'h0, 2, 1};
    run_access("LHU", 3'd5, 2'd0, 32'h12, 32'h0, 32'h80112233, 1, e);
    e = '{"LH_slow", 32'hFFFF8011, 1'b0, 8'h00, 4'hF, 1'b0, 32'h0, 4, 3};
    run_access("LH_slow", 3'd2, 2'd0, 32'h02, 32'h0, 32'h80112233, 3, e);

    e = '{"SB", 32'h0, 1'b0, 8'h04, 4'b0010, 1'b1, 32'hA5A5A5A5, 2, 1};
    run_access("SB", 3'd0, 2'd1, 32'h05, 32'h000000A5, 32'h0, 1, e);
    e = '{"SH", 32'h0, 1'b0, 8'h04, 4'b1100, 1'b1, 32'h12341234, 2, 1};
    run_access("SH", 3'd0, 2'd2, 32'h06, 32'h00001234, 32'h0, 1, e);
    // Write priority: read code present alongside a store.
    e = '{"SW_prio", 32'h0, 1'b0, 8'h08, 4'hF, 1'b1, 32'hCAFEF00D, 3, 2};
    run_access("SW_prio", 3'd3, 2'd3, 32'h08, 32'hCAFEF00D, 32'h0, 2, e);

    run_misalign("SH_mis", 3'd0, 2'd2, 32'h01);

    e = '{"LW_ok", 32'h01234567, 1'b0, 8'h20, 4'hF, 1'b0, 32'h0, 2, 1};
    run_access("LW_ok", 3'd3, 2'd0, 32'h20, 32'h0, 32'h01234567, 1, e);
    e = '{"timeout", 32'h0, 1'b1, 8'h30, 4'hF, 1'b0, 32'h0, 5, 4};
    run_access("timeout", 3'd3, 2'd0, 32'h30, 32'h0, 32'hFFFFFFFF, 0, e);
    @(negedge clk);
    #1;
    check("post_timeout err", 32'(bus_err), 32'd0);
    check("post_timeout stall", 32'(stall), 32'd0);

    // Async reset in the middle of an outstanding read.
    @(negedge clk);
    mem_read = 3'd3;
    r        = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst req", 32'(bus_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
